// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: measures high/low/period run lengths of a same-domain
// divided clock in clk cycles and checks them against the expected ratio N.
// Ports: clk, rst (sync, active-high), en (soft reset when low), div_clk in;
//   high_cnt/low_cnt [CW], period [CW+1], meas_valid, period_ok, duty_ok,
//   locked, err (sticky), overflow (sticky) out.
module clk_ratio_monitor #(
  parameter int N          = 8,
  parameter int CW         = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          div_clk,
  output logic [CW-1:0] high_cnt,
  output logic [CW-1:0] low_cnt,
  output logic [CW:0]   period,
  output logic          meas_valid,
  output logic          period_ok,
  output logic          duty_ok,
  output logic          locked,
  output logic          err,
  output logic          overflow
);

  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int PW = CW + 1;
  localparam logic [CW-1:0] RUN_ONE  = {{(CW-1){1'b0}}, 1'b1};
  // One below all-ones: the next counted sample would saturate.
  localparam logic [CW-1:0] RUN_LAST = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [PW-1:0] N_P      = PW'(N);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);
  localparam logic [LW-1:0] LOCK_ONE = LW'(1);
  localparam bit            N_ODD    = (N % 2) != 0;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

  state_t        state, state_d;
  logic          s;
  logic [CW-1:0] hi_run, hi_d;
  logic [CW-1:0] lo_run, lo_d;
  logic [LW-1:0] lock_cnt, lock_d;
  logic          done, sat;
  logic [PW-1:0] sum;
  logic [CW-1:0] diff;
  logic          per_ok_d, duty_ok_d, good;
  logic          locked_d, err_d;

  // Same clock domain: a single register is enough, no synchronizer.
  // Left unreset so a high level present at reset is never mistaken
  // for a fresh rising edge.
  always_ff @(posedge clk) begin
    s <= div_clk;
  end

  always_comb begin
    state_d = state;
    hi_d    = hi_run;
    lo_d    = lo_run;
    done    = 1'b0;
    sat     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!s) state_d = ARM;
      end
      ARM: begin
        if (s) begin
          state_d = HIGH;
          hi_d    = RUN_ONE;
        end
      end
      HIGH: begin
        if (s) begin
          if (hi_run == RUN_LAST) sat = 1'b1;
          else hi_d = hi_run + RUN_ONE;
        end else begin
          state_d = LOW;
          lo_d    = RUN_ONE;
        end
      end
      LOW: begin
        if (!s) begin
          if (lo_run == RUN_LAST) sat = 1'b1;
          else lo_d = lo_run + RUN_ONE;
        end else begin
          done    = 1'b1;
          state_d = HIGH;
          hi_d    = RUN_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (sat) begin
      state_d = IDLE;
      hi_d    = '0;
      lo_d    = '0;
    end
  end

  // Odd N: posedge sampling of a 50 % dual-edge clock gives runs that
  // differ by exactly one.
  always_comb begin
    sum       = {1'b0, hi_run} + {1'b0, lo_run};
    diff      = (hi_run > lo_run) ? (hi_run - lo_run)
                                  : (lo_run - hi_run);
    per_ok_d  = (sum == N_P);
    duty_ok_d = N_ODD ? (diff == RUN_ONE) : (diff == '0);
    good      = per_ok_d && duty_ok_d;
  end

  always_comb begin
    lock_d   = lock_cnt;
    locked_d = locked;
    err_d    = err;
    if (sat || (done && !good)) begin
      lock_d   = '0;
      locked_d = 1'b0;
      err_d    = err | locked;
    end else if (done) begin
      if (lock_cnt != LOCK_MAX) lock_d = lock_cnt + LOCK_ONE;
      locked_d = (lock_d == LOCK_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hi_run     <= '0;
      lo_run     <= '0;
      lock_cnt   <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      period_ok  <= 1'b0;
      duty_ok    <= 1'b0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      overflow   <= 1'b0;
    end else if (!en) begin
      state      <= IDLE;
      hi_run     <= '0;
      lo_run     <= '0;
      lock_cnt   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      hi_run     <= hi_d;
      lo_run     <= lo_d;
      lock_cnt   <= lock_d;
      meas_valid <= done;
      locked     <= locked_d;
      err        <= err_d;
      if (sat) overflow <= 1'b1;
      if (done) begin
        high_cnt  <= hi_run;
        low_cnt   <= lo_run;
        period    <= sum;
        period_ok <= per_ok_d;
        duty_ok   <= duty_ok_d;
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb_clk_ratio_monitor: drives one div_clk into N=8 and N=7 monitors and
// compares every cycle against a sample-history reference model.
module tb_clk_ratio_monitor;

  localparam int CW   = 6;
  localparam int RMAX = (1 << CW) - 1;
  localparam int LK   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic div_clk = 1'b0;

  logic [CW-1:0] hc8, lc8, hc7, lc7;
  logic [CW:0]   pr8, pr7;
  logic mv8, pok8, dok8, lk8, er8, ov8;
  logic mv7, pok7, dok7, lk7, er7, ov7;

  always #5 clk = ~clk;

  clk_ratio_monitor #(.N(8), .CW(CW), .LOCK_COUNT(LK)) u8 (
    .clk(clk), .rst(rst), .en(en), .div_clk(div_clk),
    .high_cnt(hc8), .low_cnt(lc8), .period(pr8),
    .meas_valid(mv8), .period_ok(pok8), .duty_ok(dok8),
    .locked(lk8), .err(er8), .overflow(ov8)
  );

  clk_ratio_monitor #(.N(7), .CW(CW), .LOCK_COUNT(LK)) u7 (
    .clk(clk), .rst(rst), .en(en), .div_clk(div_clk),
    .high_cnt(hc7), .low_cnt(lc7), .period(pr7),
    .meas_valid(mv7), .period_ok(pok7), .duty_ok(dok7),
    .locked(lk7), .err(er7), .overflow(ov7)
  );

  int total = 0;
  int bad = 0;

  // Reference model: history of samples since the last clear.
  bit hist[$];
  bit last_v = 1'b0;
  int m_hi = 0;
  int m_lo = 0;
  bit m_mv = 1'b0;
  bit m_ov = 1'b0;
  bit m_pok[2];
  bit m_dok[2];
  bit m_lk[2];
  bit m_er[2];
  int m_lc[2];
  int nval[2] = '{8, 7};

  task automatic chk(string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int run_len(int idx);
    int c = 0;
    bit v = hist[idx];
    while (idx >= 0 && hist[idx] == v) begin
      c++;
      idx--;
    end
    return c;
  endfunction

  task automatic clear_lock(bit flag_err);
    for (int i = 0; i < 2; i++) begin
      if (flag_err) m_er[i] = m_er[i] | m_lk[i];
      else m_er[i] = 1'b0;
      m_lk[i] = 1'b0;
      m_lc[i] = 0;
    end
  endtask

  // r/e: controls seen at this edge; x: sample captured one edge earlier.
  task automatic model(bit r, bit e, bit x);
    int n, rl, j, h, l, d;
    bit meas, counted;
    m_mv = 1'b0;
    if (r) begin
      hist.delete();
      m_hi = 0;
      m_lo = 0;
      m_ov = 1'b0;
      clear_lock(1'b0);
      for (int i = 0; i < 2; i++) begin
        m_pok[i] = 1'b0;
        m_dok[i] = 1'b0;
      end
      return;
    end
    if (!e) begin
      hist.delete();
      m_ov = 1'b0;
      clear_lock(1'b0);
      return;
    end
    hist.push_back(x);
    n = hist.size();
    rl = run_len(n - 1);
    meas = 1'b0;
    h = 0;
    l = 0;
    // A measurement needs low run, preceded by high run, preceded by a low.
    if (x && rl == 1 && n >= 2) begin
      l = run_len(n - 2);
      j = n - 2 - l;
      if (j >= 0) begin
        h = run_len(j);
        if (j - h >= 0) meas = 1'b1;
      end
    end
    if (meas) begin
      m_mv = 1'b1;
      m_hi = h;
      m_lo = l;
      d = (h > l) ? h - l : l - h;
      for (int i = 0; i < 2; i++) begin
        m_pok[i] = (h + l == nval[i]);
        m_dok[i] = (nval[i] % 2 == 0) ? (d == 0) : (d == 1);
        if (m_pok[i] && m_dok[i]) begin
          if (m_lc[i] < LK) m_lc[i]++;
          m_lk[i] = (m_lc[i] == LK);
        end else begin
          m_er[i] = m_er[i] | m_lk[i];
          m_lk[i] = 1'b0;
          m_lc[i] = 0;
        end
      end
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b1);
    end else begin
      j = n - rl - 1;
      if (x) counted = (j >= 0);
      else counted = (j >= 0) && (j - run_len(j) >= 0);
      if (counted && rl == RMAX) begin
        m_ov = 1'b1;
        clear_lock(1'b1);
        hist.delete();
      end
    end
  endtask

  task automatic check_all();
    chk("mv8", mv8, m_mv);
    chk("hi8", hc8, m_hi);
    chk("lo8", lc8, m_lo);
    chk("per8", pr8, m_hi + m_lo);
    chk("pok8", pok8, m_pok[0]);
    chk("dok8", dok8, m_dok[0]);
    chk("lk8", lk8, m_lk[0]);
    chk("err8", er8, m_er[0]);
    chk("ovf8", ov8, m_ov);
    chk("mv7", mv7, m_mv);
    chk("hi7", hc7, m_hi);
    chk("lo7", lc7, m_lo);
    chk("per7", pr7, m_hi + m_lo);
    chk("pok7", pok7, m_pok[1]);
    chk("dok7", dok7, m_dok[1]);
    chk("lk7", lk7, m_lk[1]);
    chk("err7", er7, m_er[1]);
    chk("ovf7", ov7, m_ov);
  endtask

  task automatic cyc(bit v, bit r = 1'b0, bit e = 1'b1);
    bit old;
    old = last_v;
    div_clk = v;
    rst = r;
    en = e;
    @(posedge clk);
    #1;
    model(r, e, old);
    last_v = v;
    check_all();
  endtask

  task automatic per(int h, int l);
    repeat (h) cyc(1'b1);
    repeat (l) cyc(1'b0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 2; i++) begin
      m_pok[i] = 1'b0;
      m_dok[i] = 1'b0;
      m_lk[i] = 1'b0;
      m_er[i] = 1'b0;
      m_lc[i] = 0;
    end
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    // even ratio
    repeat (6) per(4, 4);
    // odd ratio
    repeat (3) begin
      per(4, 3);
      per(3, 4);
    end
    // duty fault while locked
    repeat (5) per(4, 4);
    per(5, 3);
    repeat (5) per(4, 4);
    // period fault
    cyc(1'b0, 1'b1, 1'b1);
    repeat (6) per(5, 5);
    // stuck high after lock
    repeat (5) per(4, 4);
    repeat (70) cyc(1'b1);
    repeat (6) per(4, 4);
    // reset in the middle of a high phase
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1);
    cyc(1'b0);
    repeat (6) per(4, 4);
    // enable dropped mid-period
    cyc(1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0);
    repeat (6) per(4, 4);
    // minimum pulses
    repeat (5) per(1, 1);
    // randomized periods
    repeat (80) begin
      k = $urandom_range(0, 5);
      case (k)
        0, 1: per(4, 4);
        2: begin
          per(4, 3);
          per(3, 4);
        end
        3: per($urandom_range(1, 7), $urandom_range(1, 7));
        4: per($urandom_range(3, 5), $urandom_range(3, 5));
        default: cyc($urandom_range(0, 1) == 1, 1'b0, 1'b0);
      endcase
    end
    // stuck low after lock
    repeat (5) per(4, 4);
    repeat (70) cyc(1'b0);
    repeat (6) per(4, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_ratio_monitor.md
# clk_ratio_monitor

Single-clock checker that measures a divided clock produced in the same domain, e.g. by the dual-edge divide-by-N clock divider. It reports the high-phase, low-phase and period lengths in `clk` cycles, checks them against the expected ratio N, and raises lock, error and overflow status. It is the receiving end of the divider and is used both in silicon (ratio self-check) and as a reusable bench checker.

## Interface
- `N`, default 8: expected divide ratio, ≥ 2.
- `CW`, default 16: run-length counter width.
- `LOCK_COUNT`, default 4: consecutive good periods required to assert `locked`, ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  monitor enable; low acts as soft reset (see Operation).
- `div_clk`  in  1  divided clock under test, generated in the `clk` domain.
- `high_cnt`  out  CW  sampled high-phase length of the last completed period.
- `low_cnt`  out  CW  sampled low-phase length of the last completed period.
- `period`  out  CW+1  `high_cnt + low_cnt`.
- `meas_valid`  out  1  one-cycle pulse when the measurement outputs update.
- `period_ok`  out  1  last `period == N`.
- `duty_ok`  out  1  duty check result for the last measurement.
- `locked`  out  1  `LOCK_COUNT` consecutive good measurements seen.
- `err`  out  1  sticky; a bad measurement occurred while `locked` was 1.
- `overflow`  out  1  sticky; a run counter saturated.

## Operation
- `div_clk` is registered once into `s`. The FSM acts on `s`. No synchronizer is used, because `div_clk` is in the same domain.
- FSM states:
  - IDLE: if `s == 0`, go to ARM.
  - ARM: if `s == 1`, go to HIGH with `hi_run = 1`.
  - HIGH: if `s == 1`, increment `hi_run`. If `s == 0`, go to LOW with `lo_run = 1`.
  - LOW: if `s == 0`, increment `lo_run`. If `s == 1`, complete a period (see below), then go to HIGH with `hi_run = 1`.
- Period completion registers `high_cnt = hi_run`, `low_cnt = lo_run`, `period = hi_run + lo_run`, `period_ok` and `duty_ok`, and pulses `meas_valid`. All of these happen in the same cycle.
- Duty rule:
  - N even: `high_cnt == low_cnt`.
  - N odd: `|high_cnt − low_cnt| == 1`. This is required because posedge sampling of a dual-edge 50 % output gives alternating (N+1)/2 and (N−1)/2 runs.
- Good measurement means `period_ok && duty_ok`.
- Lock counter, saturating at `LOCK_COUNT`:
  - It increments on each good measurement and clears on each bad one.
  - `locked = 1` once it reaches `LOCK_COUNT`.
  - A bad measurement clears `locked` in the same update.
  - If `locked` was 1 at that moment, `err` is also set.
- Saturation: if `hi_run` or `lo_run` reaches 2^CW−1 while still counting:
  - set `overflow`;
  - clear `locked` and the lock counter (`err` is also set if `locked` was 1);
  - go to IDLE;
  - no `meas_valid` is generated.
- `en = 0`: FSM goes to IDLE, run counters and lock counter are cleared, and `locked`, `err`, `overflow` and `meas_valid` are cleared. `high_cnt`, `low_cnt`, `period`, `period_ok` and `duty_ok` hold their values.
- The first measurement after reset or enable is always a full period, because a real rising edge is required after a low sample.

## Timing
- Reset: on the first rising edge with `rst = 1`, every output is 0, the FSM is in IDLE, and all counters are 0. `rst` has priority over `en`.
- Latency: a `div_clk` rising edge captured into `s` at edge k is detected at edge k+1. `meas_valid` and the updated outputs are visible after edge k+1 and last one cycle.
- A measurement that makes the lock counter reach `LOCK_COUNT` asserts `locked` in the same cycle as its `meas_valid`.
- Minimum measurable input: high ≥ 1 and low ≥ 1 sampled cycles. Shorter pulses are invisible by design.
- Reset or `en` low in the middle of a period discards the partial period, and no `meas_valid` is generated for it.
- Back-to-back periods: `meas_valid` pulses exactly once per `div_clk` period. The pulse spacing equals `period`.

## Test plan
- **Even ratio:** N=8, `div_clk` 4 high/4 low, `rst` released → first `meas_valid` gives `high_cnt=4`, `low_cnt=4`, `period=8`, `period_ok=duty_ok=1`; `locked=1` at the 4th `meas_valid`.
- **Odd ratio:** N=7, runs alternating 4/3 and 3/4 → every measurement has `period=7`, `duty_ok=1`; `locked` after 4 periods; `err=0`.
- **Duty fault while locked:** N=8, lock first, then one 5/3 period → `period_ok=1`, `duty_ok=0`, `locked=0`, `err=1`; `locked` returns after 4 good periods while `err` stays 1.
- **Period fault:** N=8, 5/5 periods → `period=10`, `period_ok=0`, `duty_ok=1`, `locked` never asserts.
- **Stuck input:** CW=6, `div_clk` held high after lock → `overflow=1` after 63 high samples, `locked=0`, `err=1`, no `meas_valid`; after release, the next full good period gives a valid measurement.
- **Reset mid-period:** `rst` for one cycle in the middle of the high phase → all outputs 0 on the next cycle; next `meas_valid` only after one full low→high→low→high sequence, with correct counts.
